// File: rtl/hub75_row_driver.sv
// hub75_row_driver: shifts one HUB75 row pair out, then blanks, latches and lights it; `define HUB75_BRIGHTNESS_EN adds a per-row brightness input.
module hub75_row_driver #(
  parameter int NUM_COLS  = 64,
  parameter int NUM_ROWS  = 32,
  parameter int ON_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] row_top_red,
  input  logic [NUM_COLS-1:0] row_top_green,
  input  logic [NUM_COLS-1:0] row_top_blue,
  input  logic [NUM_COLS-1:0] row_bot_red,
  input  logic [NUM_COLS-1:0] row_bot_green,
  input  logic [NUM_COLS-1:0] row_bot_blue,
  input  logic [3:0]          row_addr,
  input  logic                row_valid,
`ifdef HUB75_BRIGHTNESS_EN
  input  logic [7:0]          brightness,
`endif
  output logic                row_ready,
  output logic                row_done,
  output logic                bclk,
  output logic [2:0]          rgb_top,
  output logic [2:0]          rgb_bot,
  output logic [3:0]          addr,
  output logic                le,
  output logic                oe
);
`ifdef HUB75_BRIGHTNESS_EN
  localparam int DMAX = 255;
`else
  localparam int DMAX = ON_CYCLES;
`endif
  localparam int CMAX = 2 * NUM_COLS > DMAX ? 2 * NUM_COLS : DMAX;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [CW-1:0] LAST_SHIFT = CW'(2 * NUM_COLS - 1);

  typedef enum logic [2:0] {IDLE, SHIFT, BLANK, LATCH, SHOW} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt, cnt_nx, dur, dur_nx;
  logic [5:0][NUM_COLS-1:0] sr, sr_nx;
  logic [3:0] row_sel, row_sel_nx, addr_nx;
  logic [2:0] rgb_top_nx, rgb_bot_nx;
  logic [5:0] msb;
  logic accept, step, row_ready_nx, row_done_nx, bclk_nx, le_nx, oe_nx;

  if (NUM_ROWS / 2 > 16 || ON_CYCLES < 1) begin : g_bad_cfg
    $error("hub75_row_driver: NUM_ROWS/2 must fit a 4-bit address and ON_CYCLES must be >= 1");
  end

  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    dur_nx = dur;
    sr_nx = sr;
    row_sel_nx = row_sel;
    accept = 1'b0;
    step = 1'b0;
    case (state)
      IDLE: if (row_valid) begin
        accept = 1'b1;
        state_nx = SHIFT;
        cnt_nx = '0;
        sr_nx = {row_bot_blue, row_bot_green, row_bot_red, row_top_blue, row_top_green, row_top_red};
        row_sel_nx = row_addr;
`ifdef HUB75_BRIGHTNESS_EN
        dur_nx = CW'(brightness);
`else
        dur_nx = CW'(ON_CYCLES);
`endif
      end
      SHIFT: begin
        cnt_nx = cnt + 1'b1;
        // advance to the next column once the current bit has been clocked (odd cycle)
        step = cnt[0] && cnt != LAST_SHIFT;
        if (cnt == LAST_SHIFT) state_nx = BLANK;
        if (step) for (int i = 0; i < 6; i++) sr_nx[i] = sr[i] << 1;
      end
      BLANK: state_nx = LATCH;
      LATCH: begin
        state_nx = SHOW;
        cnt_nx = '0;
      end
      SHOW: begin
        cnt_nx = cnt + 1'b1;
        if (dur == '0 || cnt == dur - 1'b1) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
    for (int i = 0; i < 6; i++) msb[i] = sr_nx[i][NUM_COLS-1];
    rgb_top_nx = accept || step ? msb[2:0] : rgb_top;
    rgb_bot_nx = accept || step ? msb[5:3] : rgb_bot;
    addr_nx = state_nx == BLANK ? row_sel : addr;
    row_ready_nx = state_nx == IDLE;
    row_done_nx = state_nx == SHOW && (dur_nx == '0 || cnt_nx == dur_nx - 1'b1);
    bclk_nx = state_nx == SHIFT && cnt_nx[0];
    le_nx = state_nx == LATCH;
    oe_nx = !(state_nx == SHOW && dur_nx != '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      dur <= '0;
      sr <= '0;
      row_sel <= '0;
      row_ready <= 1'b1;
      row_done <= 1'b0;
      bclk <= 1'b0;
      rgb_top <= '0;
      rgb_bot <= '0;
      addr <= '0;
      le <= 1'b0;
      oe <= 1'b1;
    end else begin
      state <= state_nx;
      cnt <= cnt_nx;
      dur <= dur_nx;
      sr <= sr_nx;
      row_sel <= row_sel_nx;
      row_ready <= row_ready_nx;
      row_done <= row_done_nx;
      bclk <= bclk_nx;
      rgb_top <= rgb_top_nx;
      rgb_bot <= rgb_bot_nx;
      addr <= addr_nx;
      le <= le_nx;
      oe <= oe_nx;
    end
  end
endmodule

// File: doc/hub75_row_driver.md
HUB75_ROW_DRIVER -- requirements
Module: hub75_row_driver

Interface
REQ-001 Parameter NUM_COLS, default 64, is the number of pixel columns shifted per row.
REQ-002 Parameter NUM_ROWS, default 32, is the panel row count; the driver addresses NUM_ROWS/2 row pairs with a 4-bit address.
REQ-003 Parameter ON_CYCLES, default 16, is the SHOW duration in clk cycles when HUB75_BRIGHTNESS_EN is undefined; legal range is 1 or more.
REQ-004 Port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-006 Ports row_top_red, row_top_green, row_top_blue, input, NUM_COLS bits each: top-half pixel planes.
REQ-007 Ports row_bot_red, row_bot_green, row_bot_blue, input, NUM_COLS bits each: bottom-half pixel planes.
REQ-008 Port row_addr, input, 4 bits: row-pair address for the offered row.
REQ-009 Port row_valid, input, 1 bit: the offered row is valid.
REQ-010 Port row_ready, output, 1 bit: the driver can accept a row.
REQ-011 Port row_done, output, 1 bit: one-cycle pulse when the row's display period ends.
REQ-012 Port bclk, output, 1 bit: panel shift clock.
REQ-013 Port rgb_top, output, 3 bits: {blue, green, red} top serial data.
REQ-014 Port rgb_bot, output, 3 bits: {blue, green, red} bottom serial data.
REQ-015 Port addr, output, 4 bits: panel row address.
REQ-016 Port le, output, 1 bit: latch enable, active high.
REQ-017 Port oe, output, 1 bit: output enable; 1 blanks the panel and 0 lights it.

Function
REQ-018 The FSM SHALL have states IDLE, SHIFT, BLANK, LATCH and SHOW, and all outputs SHALL be registered.
REQ-019 row_ready SHALL be 1 only in IDLE, and a row is accepted in the cycle T where row_valid and row_ready are both 1; the six planes and row_addr are captured at T.
REQ-020 SHIFT SHALL occupy cycles T+1..T+2*NUM_COLS.
REQ-021 In SHIFT, bit k (k = 0..NUM_COLS-1, MSB first, i.e. index NUM_COLS-1-k) SHALL drive rgb_top/rgb_bot with bclk=0 in the even cycle, then hold the data with bclk=1 in the odd cycle.
REQ-022 BLANK SHALL last 1 cycle (T+2*NUM_COLS+1) with oe=1, bclk=0, and addr updated to the captured row_addr.
REQ-023 LATCH SHALL last 1 cycle with le=1; le SHALL be 0 in every other state.
REQ-024 SHOW SHALL drive oe=0 for D cycles (D = ON_CYCLES, or per REQ-033), and row_done SHALL pulse in SHOW's last cycle; the next state is IDLE.
REQ-025 oe SHALL be 1 in every state except SHOW.
REQ-026 rgb_top, rgb_bot and addr SHALL hold their last values outside SHIFT and BLANK.
REQ-027 row_valid deasserting outside IDLE SHALL have no effect, and input data changes after acceptance SHALL be ignored.
REQ-028 Back-to-back rows: the earliest next acceptance SHALL be the cycle after row_done.

Reset
REQ-029 While reset=1, the outputs SHALL be: state IDLE, row_ready=1, row_done=0, bclk=0, rgb_top=0, rgb_bot=0, addr=0, le=0, oe=1, shift registers cleared.
REQ-030 A reset asserted mid-row SHALL abort the transfer immediately, with no le pulse and no row_done.
REQ-031 After reset deasserts, the first acceptance is possible on the first rising clk edge.

Configuration
REQ-032 Macro HUB75_BRIGHTNESS_EN undefined: SHOW lasts exactly ON_CYCLES cycles and there is no brightness port.
REQ-033 Macro HUB75_BRIGHTNESS_EN defined: an input port brightness, 8 bits, is added and sampled at acceptance; D = brightness.
REQ-034 With HUB75_BRIGHTNESS_EN defined and brightness=0, SHOW SHALL be skipped: oe stays 1, row_done pulses in the cycle after LATCH, and the FSM returns to IDLE.

Verification
REQ-035 Reset pulse mid-SHIFT (cycle T+40) -> outputs match REQ-029 within the same cycle, and no le pulse occurs.
REQ-036 Accept a row with top_red=64'h8000_0000_0000_0001 and all other planes 0, addr=4'h5 -> rgb_top[0]=1 on shift bits 0 and 63 only; 64 bclk rising edges; a receiver model latches top.red=64'h8000_0000_0000_0001.
REQ-037 Timing for the REQ-036 row with ON_CYCLES=16 -> addr=5 at T+129, le=1 at T+130, oe=0 T+131..T+146, row_done at T+146, row_ready=1 at T+147.
REQ-038 row_valid held high with two rows of addr 3 then 4 -> second acceptance at T+147, and addr transitions 3->4 only in the second BLANK.
REQ-039 With HUB75_BRIGHTNESS_EN defined and brightness=0 -> oe never 0, and row_done at T+131.
REQ-040 With HUB75_BRIGHTNESS_EN defined and brightness=255 -> oe=0 for exactly 255 cycles.
